// File: rtl/cosim_chk_pkg.sv
// ============================================================
// Module  : cosim_chk_pkg -- shared state enum and default sizes
// Revision: 1.0
// ============================================================
`default_nettype none

package cosim_chk_pkg;

    localparam int c_DEF_WIDTH      = 128;
    localparam int c_DEF_CNT_W      = 16;
    localparam int c_DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

endpackage

`default_nettype wire

// File: rtl/cosim_vec_fifo.sv
// ============================================================
// Module  : cosim_vec_fifo -- synchronous expected-vector FIFO
// Revision: 1.0
// ============================================================
`default_nettype none

module cosim_vec_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [c_OCC_W-1:0] occ_q;
    logic               w_push;
    logic               w_pop;

    assign full   = (occ_q == c_OCC_W'(DEPTH));
    assign empty  = (occ_q == '0);
    assign head   = mem_q[rd_ptr_q];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Occupancy, not pointer equality, tells full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= (wr_ptr_q == c_PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= (rd_ptr_q == c_PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (w_pop && !w_push) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cosim_out_checker.sv
// ============================================================
// Module  : cosim_out_checker -- masked compare of DUT output stream vs expected
// Revision: 1.0
// ============================================================
`default_nettype none

module cosim_out_checker
    import cosim_chk_pkg::*;
#(
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int NUM_VECS   = 16,
    parameter int FIFO_DEPTH = c_DEF_FIFO_DEPTH,
    parameter int CNT_W      = c_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [WIDTH-1:0] exp_data,
    input  logic             dut_valid,
    input  logic [WIDTH-1:0] dut_data,
    input  logic [WIDTH-1:0] cmp_mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             underflow,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_diff
);

    chk_state_e       state_q;
    logic             chk_vld_q;
    logic             chk_err_q;
    logic             chk_unf_q;
    logic [WIDTH-1:0] chk_diff_q;
    logic [CNT_W-1:0] vec_count_q;
    logic [CNT_W-1:0] vec_count_d;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] err_count_d;
    logic [CNT_W-1:0] first_idx_q;
    logic [WIDTH-1:0] first_diff_q;
    logic             underflow_q;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [WIDTH-1:0] w_fifo_head;
    logic             w_sample;
    logic             w_unf;
    logic             w_pop;
    logic             w_push;
    logic             w_flush;
    logic [WIDTH-1:0] w_diff;
    logic             w_mismatch;

    cosim_vec_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .pop       (w_pop),
        .flush     (w_flush),
        .push_data (exp_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_fifo_head)
    );

    assign exp_ready = (state_q == RUN) && !w_fifo_full;

    // An empty FIFO never bypasses a same-cycle push: the sample is an underflow.
    always_comb begin
        w_sample   = (state_q == RUN) && dut_valid;
        w_unf      = w_sample && w_fifo_empty;
        w_pop      = w_sample && !w_fifo_empty;
        w_push     = exp_valid && exp_ready;
        w_flush    = start && (state_q != RUN);
        w_diff     = w_fifo_empty ? cmp_mask : ((dut_data ^ w_fifo_head) & cmp_mask);
        w_mismatch = w_fifo_empty || (|w_diff);
        vec_count_d = vec_count_q + 1'b1;
        err_count_d = err_count_q;
        if (chk_err_q && !(&err_count_q)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            chk_vld_q    <= 1'b0;
            chk_err_q    <= 1'b0;
            chk_unf_q    <= 1'b0;
            chk_diff_q   <= '0;
            vec_count_q  <= '0;
            err_count_q  <= '0;
            first_idx_q  <= '0;
            first_diff_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            chk_vld_q  <= w_sample;
            chk_err_q  <= w_sample && w_mismatch;
            chk_unf_q  <= w_unf;
            chk_diff_q <= w_diff;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        vec_count_q  <= '0;
                        err_count_q  <= '0;
                        first_idx_q  <= '0;
                        first_diff_q <= '0;
                        underflow_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (chk_vld_q) begin
                        vec_count_q <= vec_count_d;
                        err_count_q <= err_count_d;
                        underflow_q <= underflow_q | chk_unf_q;
                        if (chk_err_q && (err_count_q == '0)) begin
                            first_idx_q  <= vec_count_q;
                            first_diff_q <= chk_diff_q;
                        end
                        // A sample popped on the closing cycle belongs to no run.
                        if (vec_count_d == CNT_W'(NUM_VECS)) begin
                            state_q   <= DONE;
                            chk_vld_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign pass           = (state_q == DONE) && (err_count_q == '0) && !underflow_q;
    assign underflow      = underflow_q;
    assign vec_count      = vec_count_q;
    assign err_count      = err_count_q;
    assign first_err_idx  = first_idx_q;
    assign first_err_diff = first_diff_q;

endmodule

`default_nettype wire

// File: tb/tb_cosim_out_checker.sv
// ============================================================
// Module  : tb_cosim_out_checker -- self-checking bench for cosim_out_checker
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_cosim_out_checker;

    localparam int W  = 128;
    localparam int NV = 4;
    localparam int D  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          exp_valid = 1'b0;
    logic          dut_valid = 1'b0;
    logic [W-1:0]  exp_data = '0;
    logic [W-1:0]  dut_data = '0;
    logic [W-1:0]  cmp_mask = '1;
    logic          exp_ready, busy, done, pass, underflow;
    logic [CW-1:0] vec_count, err_count, first_err_idx;
    logic [W-1:0]  first_err_diff;

    cosim_out_checker #(
        .WIDTH      (W),
        .NUM_VECS   (NV),
        .FIFO_DEPTH (D),
        .CNT_W      (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .exp_valid      (exp_valid),
        .exp_ready      (exp_ready),
        .exp_data       (exp_data),
        .dut_valid      (dut_valid),
        .dut_data       (dut_data),
        .cmp_mask       (cmp_mask),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .underflow      (underflow),
        .vec_count      (vec_count),
        .err_count      (err_count),
        .first_err_idx  (first_err_idx),
        .first_err_diff (first_err_diff)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    // Reference model: run phase, queue of buffered expected vectors, run totals.
    int           m_phase = 0;   // 0 idle, 1 running, 2 finished
    logic [W-1:0] m_q[$];
    int           m_vec = 0, m_err = 0, m_fidx = 0;
    bit           m_unf = 0;
    logic [W-1:0] m_fdiff = '0;
    bit           p_v = 0, p_e = 0, p_u = 0;
    logic [W-1:0] p_d = '0;
    bit           last_rdy;

    function automatic bit m_ready();
        return (m_phase == 1) && (m_q.size() < D);
    endfunction

    task automatic model_edge();
        int           ph0;
        bit           nv, ne, nu, rdy;
        logic [W-1:0] nd;
        if (!rst_n) begin
            m_phase = 0; m_q.delete(); m_vec = 0; m_err = 0; m_fidx = 0;
            m_unf = 0; m_fdiff = '0; p_v = 0; p_e = 0; p_u = 0; p_d = '0;
            return;
        end
        ph0 = m_phase;
        rdy = m_ready();
        nv = 0; ne = 0; nu = 0; nd = '0;
        if (ph0 == 1 && dut_valid) begin
            nv = 1;
            if (m_q.size() == 0) begin
                nu = 1; ne = 1; nd = cmp_mask;
            end else begin
                nd = (dut_data ^ m_q.pop_front()) & cmp_mask;
                ne = (nd != '0);
            end
        end
        if (rdy && exp_valid) m_q.push_back(exp_data);
        if (ph0 == 1 && p_v) begin
            if (p_e) begin
                if (m_err == 0) begin m_fidx = m_vec; m_fdiff = p_d; end
                if (m_err < (1 << CW) - 1) m_err++;
            end
            m_unf = m_unf | p_u;
            m_vec++;
            if (m_vec == NV) begin m_phase = 2; nv = 0; end
        end
        if ((ph0 == 0 || ph0 == 2) && start) begin
            m_phase = 1; m_q.delete(); m_vec = 0; m_err = 0; m_fidx = 0;
            m_unf = 0; m_fdiff = '0;
        end
        p_v = nv; p_e = ne; p_u = nu; p_d = nd;
    endtask

    task automatic cmp_all();
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        chk("pass", pass, (m_phase == 2) && (m_err == 0) && !m_unf);
        chk("underflow", underflow, m_unf);
        chk("vec_count", vec_count, m_vec);
        chk("err_count", err_count, m_err);
        chk("first_err_idx", first_err_idx, m_fidx);
        chk("first_err_diff", first_err_diff, m_fdiff);
    endtask

    task automatic step(input bit st, input bit ev, input logic [W-1:0] ed,
                        input bit dv, input logic [W-1:0] dd);
        start = st; exp_valid = ev; exp_data = ed; dut_valid = dv; dut_data = dd;
        #1;
        last_rdy = exp_ready;
        chk("exp_ready", exp_ready, m_ready());
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
    endtask

    logic [W-1:0] vexp[4];
    logic [W-1:0] vdut[4];

    task automatic run_pairs();
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 1, vexp[i], 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, vdut[i]);
        chk("done_before_latency", done, 0);
        step(0, 0, '0, 0, '0);
        chk("done_after_latency", done, 1);
    endtask

    typedef struct {
        bit st; bit ev; int ed; bit dv; int dd;
        bit rdy; bit busy; bit done; bit pass; int vec; int err;
    } vec_t;

    initial begin
        vec_t tbl[12];
        int   cyc;
        logic [W-1:0] dd;

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 2, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 3, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 4, 0, 0, 1, 1, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 5, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[6]  = '{0, 1, 5, 1, 1, 0, 1, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, 5, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 1, 2, 0, 1, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 1, 3, 1, 1, 0, 0, 2, 0};
        tbl[10] = '{0, 0, 0, 1, 4, 1, 1, 0, 0, 3, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 4, 0};

        rst_n = 1'b0;
        @(posedge clk); #1;
        step(0, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0);
        chk("rst_exp_ready", exp_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_vec_count", vec_count, 0);
        rst_n = 1'b1;

        // FIFO fill / full / one-pop recovery, then a clean four-vector run
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].st, tbl[i].ev, W'(tbl[i].ed), tbl[i].dv, W'(tbl[i].dd));
            chk($sformatf("tbl%0d_rdy", i), last_rdy, tbl[i].rdy);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].done);
            chk($sformatf("tbl%0d_pass", i), pass, tbl[i].pass);
            chk($sformatf("tbl%0d_vec", i), vec_count, tbl[i].vec);
            chk($sformatf("tbl%0d_err", i), err_count, tbl[i].err);
        end

        for (int i = 0; i < 4; i++) vexp[i] = {$urandom, $urandom, $urandom, $urandom};

        vdut = vexp;
        run_pairs();
        chk("match_pass", pass, 1);
        chk("match_vec", vec_count, 4);
        chk("match_err", err_count, 0);

        vdut[2][5] = ~vdut[2][5];
        run_pairs();
        chk("flip_err", err_count, 1);
        chk("flip_idx", first_err_idx, 2);
        chk("flip_diff", first_err_diff, 128'h20);
        chk("flip_pass", pass, 0);

        cmp_mask = ~(128'h20);
        run_pairs();
        chk("masked_pass", pass, 1);
        chk("masked_err", err_count, 0);
        cmp_mask = '1;

        step(1, 0, '0, 0, '0);
        step(0, 1, vexp[0], 1, vexp[0]);
        step(0, 1, vexp[1], 0, '0);
        step(0, 1, vexp[2], 1, vexp[0]);
        step(0, 1, vexp[3], 1, vexp[1]);
        step(0, 0, '0, 1, vexp[2]);
        step(0, 0, '0, 0, '0);
        chk("unf_done", done, 1);
        chk("unf_flag", underflow, 1);
        chk("unf_err", err_count, 1);
        chk("unf_idx", first_err_idx, 0);
        chk("unf_diff", first_err_diff, cmp_mask);
        chk("unf_pass", pass, 0);

        // Reset lands while a check is in flight
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 1, vexp[i], 0, '0);
        step(0, 0, '0, 1, vexp[0]);
        step(0, 0, '0, 1, vexp[1]);
        step(0, 0, '0, 0, '0);
        chk("mid_vec", vec_count, 2);
        step(0, 0, '0, 1, vexp[2]);
        rst_n = 1'b0;
        step(0, 0, '0, 1, vexp[3]);
        rst_n = 1'b1;
        chk("rr_busy", busy, 0);
        chk("rr_done", done, 0);
        chk("rr_pass", pass, 0);
        chk("rr_unf", underflow, 0);
        chk("rr_vec", vec_count, 0);
        chk("rr_err", err_count, 0);
        chk("rr_idx", first_err_idx, 0);
        chk("rr_diff", first_err_diff, 0);
        chk("rr_ready", exp_ready, 0);
        vdut = vexp;
        run_pairs();
        chk("rr_rerun_pass", pass, 1);

        // Randomized runs against the model
        for (int run = 0; run < 10; run++) begin
            cmp_mask = (run % 2 == 1) ? {$urandom, $urandom, $urandom, $urandom} : '1;
            step(1, 0, '0, 0, '0);
            cyc = 0;
            while (!done && cyc < 200) begin
                dd = {$urandom, $urandom, $urandom, $urandom};
                if (m_q.size() > 0 && ($urandom % 5 != 0)) begin
                    dd = m_q[0];
                    if ($urandom % 5 == 0) dd[$urandom_range(W - 1, 0)] ^= 1'b1;
                end
                step(0, ($urandom % 2) == 1, {$urandom, $urandom, $urandom, $urandom},
                     ($urandom % 3) == 0, dd);
                cyc++;
            end
            chk("rand_run_done", done, 1);
            for (int k = 0; k < 3; k++)
                step(0, 1, {$urandom, $urandom, $urandom, $urandom}, 1,
                     {$urandom, $urandom, $urandom, $urandom});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
